// File: rtl/ctrl_mc_if.sv
// rtl/ctrl_mc_if.sv - instruction/status inputs and datapath controls of ctrl_mc
// MEM_RDY exists only when CTRL_MEM_WAIT_EN is defined.
interface ctrl_mc_if #(
    parameter int OPW   = 4,
    parameter int MMW   = 4,
    parameter int STATW = 4,
    parameter int CNTW  = 16
);
    logic [OPW-1:0]   OPCODE;
    logic [MMW-1:0]   MM;
    logic [STATW-1:0] STAT;
`ifdef CTRL_MEM_WAIT_EN
    logic             MEM_RDY;
`endif
    logic             IR_LD;
    logic             PC_INC;
    logic             PC_WE;
    logic             BR_SEL;
    logic             RD_SEL;
    logic [1:0]       ALU_OP;
    logic             STAT_LD;
    logic             MEM_REQ;
    logic             MEM_WE;
    logic             RF_WE;
    logic             WB_SEL;
    logic             HALTED;
    logic [2:0]       STATE;
    logic [CNTW-1:0]  RETIRED;

`ifdef CTRL_MEM_WAIT_EN
    modport master (
        output OPCODE, MM, STAT, MEM_RDY,
        input  IR_LD, PC_INC, PC_WE, BR_SEL, RD_SEL, ALU_OP, STAT_LD,
               MEM_REQ, MEM_WE, RF_WE, WB_SEL, HALTED, STATE, RETIRED
    );
    modport slave (
        input  OPCODE, MM, STAT, MEM_RDY,
        output IR_LD, PC_INC, PC_WE, BR_SEL, RD_SEL, ALU_OP, STAT_LD,
               MEM_REQ, MEM_WE, RF_WE, WB_SEL, HALTED, STATE, RETIRED
    );
`else
    modport master (
        output OPCODE, MM, STAT,
        input  IR_LD, PC_INC, PC_WE, BR_SEL, RD_SEL, ALU_OP, STAT_LD,
               MEM_REQ, MEM_WE, RF_WE, WB_SEL, HALTED, STATE, RETIRED
    );
    modport slave (
        input  OPCODE, MM, STAT,
        output IR_LD, PC_INC, PC_WE, BR_SEL, RD_SEL, ALU_OP, STAT_LD,
               MEM_REQ, MEM_WE, RF_WE, WB_SEL, HALTED, STATE, RETIRED
    );
`endif
endinterface

// File: rtl/ctrl_mc.sv
// rtl/ctrl_mc.sv - multicycle control FSM with sticky HALT and saturating retire counter
// Define CTRL_MEM_WAIT_EN to stretch MEM for lod/str until MEM_RDY.
module ctrl_mc #(
    parameter int OPW    = 4,
    parameter int MMW    = 4,
    parameter int STATW  = 4,
    parameter int CNTW   = 16,
    parameter int AM_IMM = 8
) (
    input logic      CLK,
    input logic      RST_F,
    ctrl_mc_if.slave bus
);
    typedef enum logic [2:0] {
        ST_START0    = 3'd0,
        ST_START1    = 3'd1,
        ST_FETCH     = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_MEM       = 3'd5,
        ST_WRITEBACK = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_LOD = OPW'(1);
    localparam logic [OPW-1:0] OP_STR = OPW'(2);
    localparam logic [OPW-1:0] OP_BRA = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE = OPW'(6);
    localparam logic [OPW-1:0] OP_ALU = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    state_t          state_q, state_d;
    logic [CNTW-1:0] retired_q, retired_d;

    logic is_lod, is_str, is_alu, is_brr, is_mem, br_taken, mem_hold;

    assign is_lod   = (bus.OPCODE == OP_LOD);
    assign is_str   = (bus.OPCODE == OP_STR);
    assign is_alu   = (bus.OPCODE == OP_ALU);
    assign is_brr   = (bus.OPCODE == OP_BRR);
    assign is_mem   = is_lod | is_str;
    assign br_taken = (bus.OPCODE == OP_BRA) | is_brr |
                      ((bus.OPCODE == OP_BNE) && ((bus.STAT & bus.MM[STATW-1:0]) == '0));

`ifdef CTRL_MEM_WAIT_EN
    assign mem_hold = is_mem & ~bus.MEM_RDY;
`else
    assign mem_hold = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q   <= ST_START0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        case (state_q)
            ST_START0:    state_d = ST_START1;
            ST_START1:    state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE:    state_d = (bus.OPCODE == OP_HLT) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_MEM;
            ST_MEM:       state_d = mem_hold ? ST_MEM : ST_WRITEBACK;
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
                // Saturate rather than wrap so long runs never read as few retirements.
                if (retired_q != {CNTW{1'b1}}) retired_d = retired_q + CNTW'(1);
            end
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_START0;
        endcase
    end

    logic       ir_ld, pc_inc, pc_we, br_sel, rd_sel, stat_ld;
    logic       mem_req, mem_we, rf_we, wb_sel, halted;
    logic [1:0] alu_op;

    always_comb begin
        ir_ld   = 1'b0;
        pc_inc  = 1'b0;
        pc_we   = 1'b0;
        br_sel  = 1'b0;
        rd_sel  = 1'b0;
        alu_op  = 2'b00;
        stat_ld = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        rf_we   = 1'b0;
        wb_sel  = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_DECODE: rd_sel = is_str;
            ST_EXECUTE: begin
                if (is_alu) begin
                    alu_op  = {bus.MM == MMW'(AM_IMM), 1'b1};
                    stat_ld = 1'b1;
                end else if (is_mem) begin
                    alu_op = 2'b11;
                end
                rd_sel = is_str;
                pc_we  = br_taken;
                br_sel = br_taken & is_brr;
            end
            ST_MEM: begin
                mem_req = is_mem;
                mem_we  = is_str;
                rd_sel  = is_str;
            end
            ST_WRITEBACK: begin
                rf_we  = is_alu | is_lod;
                wb_sel = is_lod;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.IR_LD   = ir_ld;
    assign bus.PC_INC  = pc_inc;
    assign bus.PC_WE   = pc_we;
    assign bus.BR_SEL  = br_sel;
    assign bus.RD_SEL  = rd_sel;
    assign bus.ALU_OP  = alu_op;
    assign bus.STAT_LD = stat_ld;
    assign bus.MEM_REQ = mem_req;
    assign bus.MEM_WE  = mem_we;
    assign bus.RF_WE   = rf_we;
    assign bus.WB_SEL  = wb_sel;
    assign bus.HALTED  = halted;
    assign bus.STATE   = state_q;
    assign bus.RETIRED = retired_q;
endmodule

// File: tb/tb_ctrl_mc.sv
// tb/tb_ctrl_mc.sv - table-driven and randomized checks of ctrl_mc (CNTW=16 and CNTW=3)
module tb_ctrl_mc;
    localparam logic [12:0] C_IR   = 13'h1000;
    localparam logic [12:0] C_PCI  = 13'h0800;
    localparam logic [12:0] C_PCWE = 13'h0400;
    localparam logic [12:0] C_BR   = 13'h0200;
    localparam logic [12:0] C_RD   = 13'h0100;
    localparam logic [12:0] C_ALU2 = 13'h0080;
    localparam logic [12:0] C_ALU1 = 13'h0040;
    localparam logic [12:0] C_STL  = 13'h0020;
    localparam logic [12:0] C_MRQ  = 13'h0010;
    localparam logic [12:0] C_MWE  = 13'h0008;
    localparam logic [12:0] C_RFW  = 13'h0004;
    localparam logic [12:0] C_WBS  = 13'h0002;
    localparam logic [12:0] C_HLT  = 13'h0001;

    logic       CLK = 1'b0;
    logic       RST_F = 1'b0;
    logic [3:0] opcode = '0, mm = '0, stat = '0;
    logic       mem_rdy = 1'b1;
    int         checks = 0, failures = 0;
    int         exp_ret = 0;

    always #5 CLK = ~CLK;

    ctrl_mc_if #(.CNTW(16)) bif ();
    ctrl_mc_if #(.CNTW(3))  sif ();

    assign bif.OPCODE = opcode;
    assign bif.MM     = mm;
    assign bif.STAT   = stat;
    assign sif.OPCODE = opcode;
    assign sif.MM     = mm;
    assign sif.STAT   = stat;
`ifdef CTRL_MEM_WAIT_EN
    assign bif.MEM_RDY = mem_rdy;
    assign sif.MEM_RDY = mem_rdy;
`endif

    ctrl_mc #(.CNTW(16)) dut   (.CLK(CLK), .RST_F(RST_F), .bus(bif));
    ctrl_mc #(.CNTW(3))  dut_s (.CLK(CLK), .RST_F(RST_F), .bus(sif));

    logic [12:0] got_b, got_s;
    assign got_b = {bif.IR_LD, bif.PC_INC, bif.PC_WE, bif.BR_SEL, bif.RD_SEL, bif.ALU_OP,
                    bif.STAT_LD, bif.MEM_REQ, bif.MEM_WE, bif.RF_WE, bif.WB_SEL, bif.HALTED};
    assign got_s = {sif.IR_LD, sif.PC_INC, sif.PC_WE, sif.BR_SEL, sif.RD_SEL, sif.ALU_OP,
                    sif.STAT_LD, sif.MEM_REQ, sif.MEM_WE, sif.RF_WE, sif.WB_SEL, sif.HALTED};

    typedef struct {
        logic [3:0]  op, mm, stat;
        logic [12:0] dec, exe, mem, wb;
        int          nwait;
    } vec_t;
    vec_t tbl[12];

    // Expected controls per instruction phase (0 fetch .. 4 writeback), straight from the opcode rules.
    function automatic logic [12:0] model_ctrl(int phase, int op, int m, int st);
        bit lod = (op == 1), str = (op == 2), alu = (op == 8), brr = (op == 5);
        bit taken = (op == 4) || brr || (op == 6 && ((st & m & 15) == 0));
        logic [12:0] c = '0;
        if (phase == 0) c = C_IR | C_PCI;
        if (phase == 1 && str) c |= C_RD;
        if (phase == 2) begin
            if (alu) c |= C_ALU1 | C_STL | ((m == 8) ? C_ALU2 : 13'h0);
            if (lod || str) c |= C_ALU1 | C_ALU2;
            if (str) c |= C_RD;
            if (taken) c |= C_PCWE | (brr ? C_BR : 13'h0);
        end
        if (phase == 3) begin
            if (lod || str) c |= C_MRQ;
            if (str) c |= C_MWE | C_RD;
        end
        if (phase == 4) begin
            if (alu || lod) c |= C_RFW;
            if (lod) c |= C_WBS;
        end
        return c;
    endfunction

    task automatic cycle();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string nm, input int est, input logic [12:0] ectl);
        int er = (exp_ret > 65535) ? 65535 : exp_ret;
        int es = (exp_ret > 7) ? 7 : exp_ret;
        checks++;
        if (bif.STATE !== 3'(est)) begin
            failures++;
            $display("FAIL %s state: got %0d want %0d (t=%0t)", nm, bif.STATE, est, $time);
        end
        checks++;
        if (got_b !== ectl || got_s !== ectl) begin
            failures++;
            $display("FAIL %s ctrl: got %h/%h want %h (t=%0t)", nm, got_b, got_s, ectl, $time);
        end
        checks++;
        if (bif.RETIRED !== 16'(er)) begin
            failures++;
            $display("FAIL %s retired: got %0d want %0d (t=%0t)", nm, bif.RETIRED, er, $time);
        end
        checks++;
        if (sif.RETIRED !== 3'(es) || sif.STATE !== bif.STATE) begin
            failures++;
            $display("FAIL %s small: retired got %0d want %0d state %0d", nm, sif.RETIRED, es, sif.STATE);
        end
    endtask

    // Asynchronous reset from an off-edge point, then walk START0/START1 into FETCH.
    task automatic do_reset();
        opcode = 4'd2;
        mm = 4'd8;
        RST_F = 1'b0;
        exp_ret = 0;
        #1;
        chk("reset_async", 0, 13'h0);
        cycle();
        chk("reset_held", 0, 13'h0);
        RST_F = 1'b1;
        cycle();
        chk("start1", 1, 13'h0);
        cycle();
    endtask

    task automatic run_instr(input string nm, input logic [3:0] op, input logic [3:0] m,
                             input logic [3:0] st, input logic [12:0] dec, input logic [12:0] exe,
                             input logic [12:0] mem, input logic [12:0] wb, input int nwait);
        opcode = op;
        mm = m;
        stat = st;
        mem_rdy = 1'b1;
        chk({nm, "_fetch"}, 2, C_IR | C_PCI);
        cycle();
        chk({nm, "_decode"}, 3, dec);
        cycle();
        chk({nm, "_execute"}, 4, exe);
        cycle();
`ifdef CTRL_MEM_WAIT_EN
        mem_rdy = (nwait == 0);
        chk({nm, "_mem"}, 5, mem);
        if (op == 4'd1 || op == 4'd2) begin
            for (int i = 0; i < nwait; i++) begin
                cycle();
                if (i == nwait - 1) mem_rdy = 1'b1;
                chk({nm, "_mem_wait"}, 5, mem);
            end
        end
`else
        chk({nm, "_mem"}, 5, mem);
        if (nwait < 0) chk({nm, "_mem_neg"}, 5, mem);
`endif
        cycle();
        chk({nm, "_wb"}, 6, wb);
        cycle();
        exp_ret++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'd0, 4'd0,    4'd0,    13'h0, 13'h0,                   13'h0,                 13'h0,         0};
        tbl[1]  = '{4'd8, 4'd8,    4'd0,    13'h0, C_ALU2|C_ALU1|C_STL,     13'h0,                 C_RFW,         0};
        tbl[2]  = '{4'd8, 4'd0,    4'd5,    13'h0, C_ALU1|C_STL,            13'h0,                 C_RFW,         0};
        tbl[3]  = '{4'd6, 4'b0001, 4'b0000, 13'h0, C_PCWE,                  13'h0,                 13'h0,         0};
        tbl[4]  = '{4'd6, 4'b0001, 4'b0001, 13'h0, 13'h0,                   13'h0,                 13'h0,         0};
        tbl[5]  = '{4'd5, 4'd0,    4'd0,    13'h0, C_PCWE|C_BR,             13'h0,                 13'h0,         0};
        tbl[6]  = '{4'd4, 4'd3,    4'hf,    13'h0, C_PCWE,                  13'h0,                 13'h0,         0};
        tbl[7]  = '{4'd1, 4'd0,    4'd0,    13'h0, C_ALU2|C_ALU1,           C_MRQ,                 C_RFW|C_WBS,   3};
        tbl[8]  = '{4'd2, 4'd2,    4'd0,    C_RD,  C_ALU2|C_ALU1|C_RD,      C_MRQ|C_MWE|C_RD,      13'h0,         1};
        tbl[9]  = '{4'd3, 4'd8,    4'd7,    13'h0, 13'h0,                   13'h0,                 13'h0,         2};
        tbl[10] = '{4'd6, 4'b1100, 4'b0011, 13'h0, C_PCWE,                  13'h0,                 13'h0,         0};
        tbl[11] = '{4'd1, 4'd8,    4'd9,    13'h0, C_ALU2|C_ALU1,           C_MRQ,                 C_RFW|C_WBS,   0};

        do_reset();
        run_instr("noop_first", 4'd0, 4'd0, 4'd0, 13'h0, 13'h0, 13'h0, 13'h0, 0);
        chk("noop_retired1", 2, C_IR | C_PCI);

        for (int i = 0; i < 12; i++)
            run_instr($sformatf("vec%0d", i), tbl[i].op, tbl[i].mm, tbl[i].stat,
                      tbl[i].dec, tbl[i].exe, tbl[i].mem, tbl[i].wb, tbl[i].nwait);

        for (int n = 0; n < 150; n++) begin
            int op = $urandom_range(0, 14);
            int m  = ($urandom_range(0, 3) == 0) ? 8 : $urandom_range(0, 15);
            int st = $urandom_range(0, 15);
            run_instr($sformatf("rnd%0d_op%0d", n, op), 4'(op), 4'(m), 4'(st),
                      model_ctrl(1, op, m, st), model_ctrl(2, op, m, st),
                      model_ctrl(3, op, m, st), model_ctrl(4, op, m, st),
                      $urandom_range(0, 3));
        end

        opcode = 4'd8;
        chk("midexe_fetch", 2, C_IR | C_PCI);
        cycle();
        chk("midexe_decode", 3, 13'h0);
        cycle();
        chk("midexe_execute", 4, C_ALU1 | C_STL);
        do_reset();

        for (int n = 0; n < 3; n++)
            run_instr("post_reset", 4'd0, 4'd0, 4'd0, 13'h0, 13'h0, 13'h0, 13'h0, 0);

        opcode = 4'd15;
        chk("hlt_fetch", 2, C_IR | C_PCI);
        cycle();
        chk("hlt_decode", 3, 13'h0);
        cycle();
        chk("hlt_enter", 7, C_HLT);
        for (int i = 0; i < 20; i++) begin
            opcode = 4'($urandom_range(0, 15));
            cycle();
            chk("hlt_hold", 7, C_HLT);
        end
        do_reset();
        run_instr("after_hlt", 4'd8, 4'd8, 4'd0, 13'h0, C_ALU2 | C_ALU1 | C_STL, 13'h0, C_RFW, 0);
        chk("after_hlt_retired", 2, C_IR | C_PCI);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ctrl_mc.md
Name: ctrl_mc

Overview:
Parametrised multicycle control FSM for the teaching CPU datapath, successor to the single-width control unit. Sequences each instruction through fetch/decode/execute/mem/writeback and decodes per-state datapath controls from OPCODE, MM and STAT. Adds a sticky HALT state with a HALTED output (no simulator $stop), branch resolution for bra/brr/bne, and a saturating retired-instruction counter. Sits between the instruction register and the PC, register file, ALU and data memory.

Parameters:
OPW, 4, opcode field width.
MMW, 4, addressing-mode/condition-mask field width; must be >= STATW.
STATW, 4, ALU status flag width.
CNTW, 16, retired-instruction counter width.
AM_IMM, 8, MM value selecting immediate operand B.

Ports:
CLK  in  1  clock, rising edge.
RST_F  in  1  asynchronous active-low reset.
OPCODE  in  OPW  current instruction opcode: noop=0, lod=1, str=2, bra=4, brr=5, bne=6, alu_op=8, hlt=15.
MM  in  MMW  addressing mode / bne condition mask.
STAT  in  STATW  registered ALU status flags.
MEM_RDY  in  1  memory ready; present only with CTRL_MEM_WAIT_EN.
IR_LD  out  1  load instruction register.
PC_INC  out  1  PC <= PC+1.
PC_WE  out  1  PC <= branch target.
BR_SEL  out  1  1 = relative target (brr), 0 = absolute.
RD_SEL  out  1  register-read port selects Rd (str data).
ALU_OP  out  2  bit0 = ALU result latch, bit1 = operand B immediate.
STAT_LD  out  1  latch ALU flags.
MEM_REQ  out  1  memory access request.
MEM_WE  out  1  memory write.
RF_WE  out  1  register-file write.
WB_SEL  out  1  1 = memory data, 0 = ALU result.
HALTED  out  1  core halted.
STATE  out  3  present state encoding.
RETIRED  out  CNTW  retired-instruction count.

Behaviour:
- States: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7. State register updates on rising CLK. RST_F low forces START0 and RETIRED=0 immediately, regardless of clock.
- Transitions: START0->START1->FETCH->DECODE. DECODE->HALT if OPCODE==hlt, else EXECUTE. EXECUTE->MEM->WRITEBACK->FETCH. HALT is held until reset.
- Outputs are combinational decodes of the present state plus OPCODE/MM/STAT. Every control output is 0 in START0, START1 and during reset.
- FETCH: IR_LD=1, PC_INC=1.
- DECODE: RD_SEL=1 when opcode is str.
- EXECUTE:
  - alu_op: ALU_OP={MM==AM_IMM,1}, STAT_LD=1.
  - lod/str: ALU_OP=2'b11 (address computation); RD_SEL=1 for str.
  - Branch taken: bra and brr always; bne when (STAT & MM[STATW-1:0])==0. When taken, PC_WE=1 and BR_SEL=(opcode==brr).
- MEM: MEM_REQ=1 for lod/str; MEM_WE=1 for str; RD_SEL=1 for str.
- WRITEBACK: RF_WE=1 for alu_op and lod; WB_SEL=1 for lod.
- HALT: HALTED=1; all other controls 0; RETIRED frozen.
- noop and undefined opcodes traverse every state with all controls 0 and still retire.
- Base latency is 5 cycles per instruction, FETCH through WRITEBACK. First FETCH occurs 2 cycles after reset release.
- RETIRED increments on each WRITEBACK->FETCH edge. It saturates at 2^CNTW-1 and does not wrap. hlt never retires.
- Reset asserted mid-instruction abandons the instruction; no partial retire.

Optional Feature:
CTRL_MEM_WAIT_EN:
- Defined: adds MEM_RDY. For lod/str, MEM holds while MEM_RDY=0 with MEM_REQ/MEM_WE held steady, and advances to WRITEBACK on the first cycle MEM_RDY=1. Other opcodes ignore MEM_RDY and spend exactly 1 cycle in MEM.
- Undefined: no MEM_RDY port; MEM always lasts 1 cycle.

Test Plan:
- Reset then OPCODE=noop held -> STATE sequence 0,1,2,3,4,5,6,2; RETIRED=1 after first WRITEBACK; all controls 0 outside FETCH.
- alu_op with MM=8 -> EXECUTE: ALU_OP=2'b11, STAT_LD=1; WRITEBACK: RF_WE=1, WB_SEL=0. With MM=0 -> ALU_OP=2'b01.
- bne with MM=4'b0001: STAT=4'b0000 -> PC_WE=1, BR_SEL=0 in EXECUTE; STAT=4'b0001 -> PC_WE=0. brr -> PC_WE=1, BR_SEL=1.
- lod -> MEM: MEM_REQ=1, MEM_WE=0; WRITEBACK: RF_WE=1, WB_SEL=1. str -> MEM_WE=1, RD_SEL=1, RF_WE=0. With CTRL_MEM_WAIT_EN and MEM_RDY low 3 cycles -> MEM lasts 4 cycles.
- hlt -> STATE=7, HALTED=1 from the cycle after DECODE; RETIRED unchanged for 20 cycles; RST_F pulse low -> STATE=0 asynchronously, HALTED=0.
- CNTW=3, 9 noop instructions -> RETIRED stops at 7; RST_F low mid-EXECUTE -> RETIRED=0, STATE=0.
